// File: rtl/max_min_diff_pkg.sv
// Shared types and defaults for the max-min chroma-spread mask pipeline.
//   CW_DEF / CNT_W_DEF : default channel and frame-counter widths
//   pixel_t            : packed {b,g,r} pixel at default width, r in LSBs
//   mode_e             : decision mode (single threshold / line hysteresis)
//   frame_state_e      : frame tracking FSM states
package max_min_diff_pkg;

  localparam int unsigned CW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 20;

  typedef struct packed {
    logic [CW_DEF-1:0] b;
    logic [CW_DEF-1:0] g;
    logic [CW_DEF-1:0] r;
  } pixel_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_HYST   = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

endpackage

// File: rtl/rgb_max_min.sv
// Combinational maximum and minimum of three CW-bit colour channels.
//   i_r, i_g, i_b : channel values
//   o_max, o_min  : largest / smallest channel value
module rgb_max_min
  import max_min_diff_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic [CW-1:0] i_r,
  input  logic [CW-1:0] i_g,
  input  logic [CW-1:0] i_b,
  output logic [CW-1:0] o_max,
  output logic [CW-1:0] o_min
);

  logic [CW-1:0] rg_max;
  logic [CW-1:0] rg_min;

  always_comb begin
    rg_max = (i_r > i_g) ? i_r : i_g;
    rg_min = (i_r < i_g) ? i_r : i_g;
    o_max  = (rg_max > i_b) ? rg_max : i_b;
    o_min  = (rg_min < i_b) ? rg_min : i_b;
  end

endmodule

// File: rtl/max_min_diff_mask_pipe.sv
// Three-stage pixel pipeline: diff = max(R,G,B) - min(R,G,B), foreground mask
// decision (single threshold or per-line hysteresis) and per-frame foreground
// pixel counter.
//   i_CLK, i_RST                  : clock, async active-high reset
//   i_DATA_RGB, i_DATA_VALID      : pixel {B,G,R} and qualifier
//   i_SOF, i_SOL, i_EOF           : frame/line markers, qualified by valid
//   i_H_THRESHOLD, i_L_THRESHOLD  : high/low thresholds, i_MODE decision mode
//   o_MASK, o_DIFF, o_VALID       : per-pixel result, 3 cycles after input
//   o_SOF, o_EOF                  : delayed frame markers
//   o_FG_COUNT, o_COUNT_VALID     : last frame's foreground count and pulse
module max_min_diff_mask_pipe
  import max_min_diff_pkg::*;
#(
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic [3*CW-1:0]   i_DATA_RGB,
  input  logic              i_DATA_VALID,
  input  logic              i_SOF,
  input  logic              i_SOL,
  input  logic              i_EOF,
  input  logic [CW-1:0]     i_H_THRESHOLD,
  input  logic [CW-1:0]     i_L_THRESHOLD,
  input  logic              i_MODE,
  output logic              o_MASK,
  output logic [CW-1:0]     o_DIFF,
  output logic              o_VALID,
  output logic              o_SOF,
  output logic              o_EOF,
  output logic [CNT_W-1:0]  o_FG_COUNT,
  output logic              o_COUNT_VALID
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Frame tracking and threshold shadows (shadows act as the S1 copy)
  frame_state_e state_q, state_d;
  logic         in_frame_q, in_frame_d;
  logic [CW-1:0] sh_h_q, sh_h_d, sh_l_q, sh_l_d;
  mode_e        sh_mode_q, sh_mode_d;

  // S1
  logic [3*CW-1:0] s1_pix_q, s1_pix_d;
  logic s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_sol_q, s1_sol_d;
  logic s1_eof_q, s1_eof_d, s1_fr_q, s1_fr_d;

  // S2
  logic [CW-1:0] s2_max_q, s2_max_d, s2_min_q, s2_min_d;
  logic [CW-1:0] s2_h_q, s2_h_d, s2_l_q, s2_l_d;
  mode_e         s2_mode_q, s2_mode_d;
  logic s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_sol_q, s2_sol_d;
  logic s2_eof_q, s2_eof_d, s2_fr_q, s2_fr_d;

  // S3 and frame counter
  logic [CW-1:0]    s3_diff_q, s3_diff_d;
  logic             s3_mask_q, s3_mask_d, s3_valid_q, s3_valid_d;
  logic             s3_sof_q, s3_sof_d, s3_eof_q, s3_eof_d;
  logic             hyst_q, hyst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, fg_count_q, fg_count_d;
  logic             count_valid_q, count_valid_d;

  logic             start;
  logic [CW-1:0]    mm_max, mm_min, diff, low_eff;
  logic             prev_fg, mask;
  logic [CNT_W-1:0] cnt_base, cnt_next;

  rgb_max_min #(.CW(CW)) u_max_min (
    .i_r   (s1_pix_q[CW-1:0]),
    .i_g   (s1_pix_q[2*CW-1:CW]),
    .i_b   (s1_pix_q[3*CW-1:2*CW]),
    .o_max (mm_max),
    .o_min (mm_min)
  );

  always_comb begin
    start = i_DATA_VALID & i_SOF;

    // Shadows follow the inputs while idle and reload on every SOF.
    if ((state_q == ST_IDLE) || start) begin
      sh_h_d    = i_H_THRESHOLD;
      sh_l_d    = i_L_THRESHOLD;
      sh_mode_d = mode_e'(i_MODE);
    end else begin
      sh_h_d    = sh_h_q;
      sh_l_d    = sh_l_q;
      sh_mode_d = sh_mode_q;
    end

    // FSM leaves ACTIVE when EOF reaches S3, unless the next frame's SOF is
    // already in S1 (back-to-back frames).
    state_d = state_q;
    if (start)
      state_d = ST_ACTIVE;
    else if (s2_valid_q && s2_eof_q && !s1_sof_q)
      state_d = ST_IDLE;

    // Input-side frame membership tag: lets counting at S3 stay correct even
    // while the FSM is still finishing the previous frame.
    in_frame_d = in_frame_q;
    if (i_DATA_VALID) begin
      if (i_EOF)
        in_frame_d = 1'b0;
      else if (i_SOF)
        in_frame_d = 1'b1;
    end

    s1_pix_d   = i_DATA_RGB;
    s1_valid_d = i_DATA_VALID;
    s1_sof_d   = start;
    s1_sol_d   = i_DATA_VALID & i_SOL;
    s1_eof_d   = i_DATA_VALID & i_EOF;
    s1_fr_d    = i_DATA_VALID & (start | in_frame_q);

    s2_max_d   = mm_max;
    s2_min_d   = mm_min;
    s2_h_d     = sh_h_q;
    s2_l_d     = sh_l_q;
    s2_mode_d  = sh_mode_q;
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_sof_q;
    s2_sol_d   = s1_sol_q;
    s2_eof_d   = s1_eof_q;
    s2_fr_d    = s1_fr_q;

    diff    = s2_max_q - s2_min_q;
    low_eff = (s2_l_q < s2_h_q) ? s2_l_q : s2_h_q;
    prev_fg = hyst_q & ~(s2_sol_q | s2_sof_q);
    if ((s2_mode_q == MODE_HYST) && prev_fg)
      mask = (diff >= low_eff);
    else
      mask = (diff > s2_h_q);

    hyst_d     = s2_valid_q ? mask : hyst_q;
    s3_valid_d = s2_valid_q;
    s3_diff_d  = s2_valid_q ? diff : '0;
    s3_mask_d  = s2_valid_q & mask;
    s3_sof_d   = s2_sof_q;
    s3_eof_d   = s2_eof_q;

    cnt_d         = cnt_q;
    fg_count_d    = fg_count_q;
    count_valid_d = 1'b0;
    cnt_base      = s2_sof_q ? '0 : cnt_q;
    cnt_next      = (mask && (cnt_base != '1)) ? cnt_base + CNT_ONE : cnt_base;
    if (s2_valid_q && s2_fr_q) begin
      if (s2_eof_q) begin
        fg_count_d    = cnt_next;
        count_valid_d = 1'b1;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_next;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q       <= ST_IDLE;
      in_frame_q    <= 1'b0;
      sh_h_q        <= '0;
      sh_l_q        <= '0;
      sh_mode_q     <= MODE_SINGLE;
      s1_pix_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_sof_q      <= 1'b0;
      s1_sol_q      <= 1'b0;
      s1_eof_q      <= 1'b0;
      s1_fr_q       <= 1'b0;
      s2_max_q      <= '0;
      s2_min_q      <= '0;
      s2_h_q        <= '0;
      s2_l_q        <= '0;
      s2_mode_q     <= MODE_SINGLE;
      s2_valid_q    <= 1'b0;
      s2_sof_q      <= 1'b0;
      s2_sol_q      <= 1'b0;
      s2_eof_q      <= 1'b0;
      s2_fr_q       <= 1'b0;
      s3_diff_q     <= '0;
      s3_mask_q     <= 1'b0;
      s3_valid_q    <= 1'b0;
      s3_sof_q      <= 1'b0;
      s3_eof_q      <= 1'b0;
      hyst_q        <= 1'b0;
      cnt_q         <= '0;
      fg_count_q    <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_frame_q    <= in_frame_d;
      sh_h_q        <= sh_h_d;
      sh_l_q        <= sh_l_d;
      sh_mode_q     <= sh_mode_d;
      s1_pix_q      <= s1_pix_d;
      s1_valid_q    <= s1_valid_d;
      s1_sof_q      <= s1_sof_d;
      s1_sol_q      <= s1_sol_d;
      s1_eof_q      <= s1_eof_d;
      s1_fr_q       <= s1_fr_d;
      s2_max_q      <= s2_max_d;
      s2_min_q      <= s2_min_d;
      s2_h_q        <= s2_h_d;
      s2_l_q        <= s2_l_d;
      s2_mode_q     <= s2_mode_d;
      s2_valid_q    <= s2_valid_d;
      s2_sof_q      <= s2_sof_d;
      s2_sol_q      <= s2_sol_d;
      s2_eof_q      <= s2_eof_d;
      s2_fr_q       <= s2_fr_d;
      s3_diff_q     <= s3_diff_d;
      s3_mask_q     <= s3_mask_d;
      s3_valid_q    <= s3_valid_d;
      s3_sof_q      <= s3_sof_d;
      s3_eof_q      <= s3_eof_d;
      hyst_q        <= hyst_d;
      cnt_q         <= cnt_d;
      fg_count_q    <= fg_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign o_MASK        = s3_mask_q;
  assign o_DIFF        = s3_diff_q;
  assign o_VALID       = s3_valid_q;
  assign o_SOF         = s3_sof_q;
  assign o_EOF         = s3_eof_q;
  assign o_FG_COUNT    = fg_count_q;
  assign o_COUNT_VALID = count_valid_q;

endmodule

// File: tb/tb_max_min_diff_mask_pipe.sv
// Scoreboard bench for max_min_diff_mask_pipe (CW=8, CNT_W=4 so that counter
// saturation is reachable with short frames).
module tb_max_min_diff_mask_pipe;
  import max_min_diff_pkg::*;

  localparam int CW    = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [3*CW-1:0]   data;
  logic              valid, sof_in, sol_in, eof_in, mode_in;
  logic [CW-1:0]     h_in, l_in;
  logic              o_mask, o_valid, o_sof, o_eof, o_cv;
  logic [CW-1:0]     o_diff;
  logic [CNT_W-1:0]  o_fgc;

  max_min_diff_mask_pipe #(.CW(CW), .CNT_W(CNT_W)) dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_DATA_RGB    (data),
    .i_DATA_VALID  (valid),
    .i_SOF         (sof_in),
    .i_SOL         (sol_in),
    .i_EOF         (eof_in),
    .i_H_THRESHOLD (h_in),
    .i_L_THRESHOLD (l_in),
    .i_MODE        (mode_in),
    .o_MASK        (o_mask),
    .o_DIFF        (o_diff),
    .o_VALID       (o_valid),
    .o_SOF         (o_sof),
    .o_EOF         (o_eof),
    .o_FG_COUNT    (o_fgc),
    .o_COUNT_VALID (o_cv)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          mask;
    int          diff;
    bit          sof;
    bit          eof;
    bit          cv;
    int          fgc;
    int unsigned due;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   in_rst = 1'b1;

  // Reference model state: frame membership, shadow thresholds, line history
  bit m_active, m_prev, sh_mode;
  int m_cnt, m_fgc, sh_h, sh_l;

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev = 0; m_cnt = 0; m_fgc = 0;
    sh_h = 0; sh_l = 0; sh_mode = 0;
  endtask

  task automatic send(input int r, input int g, input int b,
                      input bit sof, input bit sol, input bit eof);
    pixel_t p;
    exp_t   e;
    int     d, le;
    bit     mk, in_fr;
    p.r = 8'(r); p.g = 8'(g); p.b = 8'(b);
    data = p; valid = 1; sof_in = sof; sol_in = sol; eof_in = eof;
    d = max3(r, g, b) - min3(r, g, b);
    if (sof || !m_active) begin
      sh_h = int'(h_in); sh_l = int'(l_in); sh_mode = mode_in;
    end
    if (sof) begin m_active = 1; m_cnt = 0; end
    in_fr = m_active;
    if (sof || sol) m_prev = 0;
    le = (sh_l < sh_h) ? sh_l : sh_h;
    mk = (sh_mode && m_prev) ? (d >= le) : (d > sh_h);
    m_prev = mk;
    e.cv = 0;
    if (in_fr) begin
      if (mk && m_cnt < CMAX) m_cnt++;
      if (eof) begin
        e.cv = 1; m_fgc = m_cnt; m_cnt = 0; m_active = 0;
      end
    end
    e.mask = mk; e.diff = d; e.sof = sof; e.eof = eof;
    e.fgc = m_fgc; e.due = cyc + 3;
    sbq.push_back(e);
    n_vec++;
    @(posedge clk); #1;
    valid = 0; sof_in = 0; sol_in = 0; eof_in = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      data = 24'($urandom); valid = 0;
      sof_in = 1'($urandom); sol_in = 1'($urandom); eof_in = 1'($urandom);
      @(posedge clk); #1;
    end
    sof_in = 0; sol_in = 0; eof_in = 0;
  endtask

  task automatic set_thr(input int h, input int l, input bit m);
    h_in = 8'(h); l_in = 8'(l); mode_in = m;
  endtask

  task automatic check_zero(input string name);
    if ({o_mask, o_diff, o_valid, o_sof, o_eof, o_fgc, o_cv} != '0) begin
      n_err++;
      $display("FAIL %s: mask=%0d diff=%0d valid=%0d sof=%0d eof=%0d fgc=%0d cv=%0d, all required 0",
               name, o_mask, o_diff, o_valid, o_sof, o_eof, o_fgc, o_cv);
    end
  endtask

  always @(negedge clk) begin
    if (!in_rst) begin
      if (o_valid) begin
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid at cycle %0d: mask=%0d diff=%0d, none expected",
                   cyc, o_mask, o_diff);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (o_mask !== e.mask || int'(o_diff) != e.diff || o_sof !== e.sof ||
              o_eof !== e.eof || o_cv !== e.cv || int'(o_fgc) != e.fgc || cyc != e.due) begin
            n_err++;
            $display("FAIL pixel: got mask=%0d diff=%0d sof=%0d eof=%0d cv=%0d fgc=%0d cyc=%0d; required mask=%0d diff=%0d sof=%0d eof=%0d cv=%0d fgc=%0d cyc=%0d",
                     o_mask, o_diff, o_sof, o_eof, o_cv, o_fgc, cyc,
                     e.mask, e.diff, e.sof, e.eof, e.cv, e.fgc, e.due);
          end
        end
      end else if (o_sof || o_eof || o_cv) begin
        n_err++;
        $display("FAIL bubble_flags at cycle %0d: sof=%0d eof=%0d cv=%0d, required 0",
                 cyc, o_sof, o_eof, o_cv);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; valid = 0; sof_in = 0; sol_in = 0; eof_in = 0; data = '0;
    set_thr(0, 0, 0);
    model_reset();
    #12;
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 0; in_rst = 0;
    idle(2);

    // Single threshold, out-of-frame pixels: masks 1,0,0 diffs 150,0,50
    set_thr(50, 0, 0);
    send(200, 100, 50, 0, 0, 0);
    send(128, 128, 128, 0, 0, 0);
    send(100, 50, 75, 0, 0, 0);
    idle(4);

    // Hysteresis line 60,30,10,30 -> 1,1,0,0; single mode -> 1,0,0,0
    set_thr(50, 20, 1);
    send(60, 0, 0, 0, 1, 0); send(30, 0, 0, 0, 0, 0);
    send(10, 0, 0, 0, 0, 0); send(30, 0, 0, 0, 0, 0);
    idle(3);
    set_thr(50, 20, 0);
    send(60, 0, 0, 0, 1, 0); send(30, 0, 0, 0, 0, 0);
    send(10, 0, 0, 0, 0, 0); send(30, 0, 0, 0, 0, 0);
    idle(3);

    // Line boundary clears hysteresis history
    set_thr(50, 20, 1);
    send(0, 60, 0, 0, 1, 0); send(0, 60, 0, 0, 0, 0);
    send(30, 0, 0, 0, 1, 0); send(30, 0, 0, 0, 0, 0);
    idle(4);

    // Frame with 2-cycle gaps, masks 1,1,0,1 -> count 3
    set_thr(50, 0, 0);
    send(100, 0, 0, 1, 1, 0); idle(2);
    send(0, 80, 0, 0, 0, 0);  idle(2);
    send(0, 0, 10, 0, 0, 0);  idle(2);
    send(90, 0, 0, 0, 0, 1);
    idle(4);

    // Threshold change mid-frame held until next SOF
    set_thr(50, 0, 0);
    send(100, 0, 0, 1, 1, 0);
    set_thr(200, 0, 0);
    send(100, 0, 0, 0, 0, 0); send(150, 0, 0, 0, 0, 0); send(0, 100, 0, 0, 0, 1);
    idle(4);
    send(100, 0, 0, 1, 1, 0); send(250, 0, 0, 0, 0, 1);
    idle(4);

    // Reset with three pixels in flight
    set_thr(10, 0, 0);
    send(100, 0, 0, 1, 1, 0); send(100, 0, 0, 0, 0, 0); send(100, 0, 0, 0, 0, 0);
    in_rst = 1; rst = 1;
    #1;
    check_zero("reset_midframe");
    @(posedge clk); #1;
    rst = 0;
    sbq.delete();
    model_reset();
    in_rst = 0;
    idle(6);
    send(100, 0, 0, 1, 1, 0); send(5, 0, 0, 0, 0, 0); send(0, 90, 0, 0, 0, 1);
    idle(4);

    // Randomised frames: saturating frames, restarts, back-to-back, strays
    for (int f = 0; f < 40; f++) begin
      bit sat;
      int len;
      sat = (f % 5 == 4);
      len = sat ? 20 : $urandom_range(1, 12);
      set_thr(sat ? 0 : $urandom_range(0, 200), $urandom_range(0, 255), 1'($urandom));
      for (int i = 0; i < len; i++) begin
        bit s_of, s_ol;
        if (i > 0 && $urandom_range(0, 3) == 0) h_in = 8'($urandom_range(0, 255));
        s_of = (i == 0) || (!sat && i > 2 && $urandom_range(0, 15) == 0);
        s_ol = (i == 0) || ($urandom_range(0, 4) == 0);
        if (sat) send(255, 0, $urandom_range(0, 200), s_of, s_ol, i == len - 1);
        else     send($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), s_of, s_ol, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(0, 2) != 0) begin
        idle(3);
        if ($urandom_range(0, 1) == 1) begin
          set_thr($urandom_range(0, 200), $urandom_range(0, 255), 1'($urandom));
          send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               0, 1'($urandom), 1'($urandom));
          idle(3);
        end
      end
    end

    for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", sbq.size());
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/max_min_diff_mask_pipe.md
Name: max_min_diff_mask_pipe

Overview:
Parametrised, pipelined successor of the chroma-spread background-removal stage. Per pixel: computes diff = max(R,G,B) - min(R,G,B) and emits a foreground mask bit. Adds configurable channel width, single-threshold or line-hysteresis decision mode, and a frame-level foreground pixel counter. Sits between pixel capture and the mask/compositing stage of the background-removal chain.

Parameters:
CW, 8, bits per colour channel; pixel word is 3*CW, packed {B,G,R} with R in the LSBs.
CNT_W, 20, width of the per-frame foreground counter.

Ports:
i_CLK  in  1  single system clock, rising edge.
i_RST  in  1  reset; asynchronous, active-high.
i_DATA_RGB  in  3*CW  pixel {B,G,R}.
i_DATA_VALID  in  1  pixel qualifier; no backpressure.
i_SOF  in  1  first pixel of frame; meaningful only with valid.
i_SOL  in  1  first pixel of line; meaningful only with valid.
i_EOF  in  1  last pixel of frame; meaningful only with valid.
i_H_THRESHOLD  in  CW  high/primary threshold.
i_L_THRESHOLD  in  CW  low threshold, hysteresis mode only.
i_MODE  in  1  0 = single threshold, 1 = hysteresis.
o_MASK  out  1  1 = foreground.
o_DIFF  out  CW  max-min value for the output pixel.
o_VALID  out  1  output qualifier.
o_SOF  out  1  delayed i_SOF.
o_EOF  out  1  delayed i_EOF.
o_FG_COUNT  out  CNT_W  foreground count of the last completed frame.
o_COUNT_VALID  out  1  one-cycle pulse when o_FG_COUNT updates.

Behaviour:
- Reset (i_RST high, async): all pipeline valids and flags cleared. o_MASK, o_DIFF, o_VALID, o_SOF, o_EOF, o_FG_COUNT and o_COUNT_VALID read 0. Threshold and mode shadows read 0. Hysteresis state = background. Frame FSM = IDLE. Reset mid-frame discards in-flight pixels; no count pulse is emitted.
- Pipeline has 3 register stages with a fixed latency of 3 cycles from input valid to o_VALID.
  - S1: register pixel, valid, SOF/SOL/EOF.
  - S2: register max and min.
  - S3: register diff, mask and flags.
  - Bubbles (valid=0) propagate unchanged. When valid=0, flags are forced to 0.
- Arithmetic: diff = max - min, unsigned, CW bits, cannot underflow.
- Frame FSM, with states IDLE and ACTIVE:
  - IDLE -> ACTIVE on valid & SOF at S1.
  - ACTIVE -> IDLE on valid & EOF at S3.
  - SOF and EOF on the same pixel: the frame is one pixel long; counted, then IDLE.
  - SOF received while ACTIVE: restarts the frame. Counter clears, no pulse, thresholds reload.
- Threshold/mode shadows:
  - Loaded from inputs every cycle while IDLE, and on valid & SOF.
  - Held constant while ACTIVE, so mid-frame input changes have no effect.
  - Shadows travel with the pixel: a pixel is always decided with the shadows in force when it entered S1.
- Mode 0: mask = (diff > H). The comparison is strict; diff == H gives 0.
- Mode 1:
  - Effective low Le = min(L, H).
  - If the previous pixel of the same line was foreground: mask = (diff >= Le). Otherwise: mask = (diff > H).
  - Hysteresis state updates only on valid pixels.
  - Forced to background before evaluating any pixel flagged SOL or SOF.
- Counter:
  - Increments on valid & mask at S3 while ACTIVE; saturates at 2^CNT_W-1.
  - On the EOF pixel at S3, the final value (including that pixel) is copied to o_FG_COUNT, o_COUNT_VALID pulses one cycle, and the internal counter clears.
  - Pixels arriving in IDLE without SOF are processed for mask output but not counted.

Decomposition:
- Package max_min_diff_pkg:
  - CW/CNT_W defaults.
  - Packed pixel struct {b,g,r}.
  - Mode enum (MODE_SINGLE, MODE_HYST).
  - Frame state enum (ST_IDLE, ST_ACTIVE).
- Sub-module rgb_max_min: combinational max/min of three CW-bit channels, instantiated between S1 and S2.

Test Plan:
- CW=8, mode 0, H=50: pixels R=200,G=100,B=50 then 128,128,128 then diff exactly 50 -> masks 1,0,0, diffs 150,0,50, each 3 cycles after input.
- Mode 1, H=50, L=20: one line with diffs 60,30,10,30 -> masks 1,1,0,0. Same sequence in mode 0 -> 1,0,0,0.
- Mode 1: two lines, line 1 ends with diff 60 (fg), line 2 starts SOL with diff 30 -> first mask of line 2 is 0.
- 4-pixel frame SOF..EOF with masks 1,1,0,1, valid gaps of 2 cycles inserted -> o_FG_COUNT=3 and a single o_COUNT_VALID pulse coincident with the o_EOF output; bubbles produce o_VALID=0.
- Change H from 50 to 200 mid-frame -> remaining pixels of the frame still use 50; next frame's SOF loads 200.
- Assert i_RST for 1 cycle mid-frame with 3 pixels in flight -> all outputs 0 immediately, no o_VALID or count pulse afterward; a new SOF frame then counts correctly from 0.
